// File: rtl/alu_issue_sequencer.sv
// Issue sequencer between ID and ID/EX: passes ALU ops through with one cycle of latency
// and splits an A-type SWAP into two MOVE micro-ops, stalling IF/ID for the second one.
module alu_issue_sequencer #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_aluop,
    input  logic [3:0]    id_funct,
    input  logic [RW-1:0] id_op1,
    input  logic [RW-1:0] id_op2,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic          flush,
    input  logic          hold,
    output logic          ex_valid,
    output logic [3:0]    ex_aluop,
    output logic [3:0]    ex_funct,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [RW-1:0] ex_wr_addr,
    output logic          ex_wr_en,
    output logic          id_stall
);

    localparam logic [3:0] AluopAType = 4'b0001;
    localparam logic [3:0] FunctSwap  = 4'b1111;
    localparam logic [3:0] FunctMove  = 4'b1110;

    typedef enum logic [0:0] {StPass, StSwap2} state_e;

    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic [3:0]    aluop_q, aluop_d;
    logic [3:0]    funct_q, funct_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [RW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_en_q, wr_en_d;
    logic [DW-1:0] sv_a_q, sv_a_d;
    logic [RW-1:0] sv_op2_q, sv_op2_d;
    logic          is_swap;
    logic          owns_wb;

    assign is_swap = id_valid && (id_aluop == AluopAType) && (id_funct == FunctSwap);
    // Load, store and branch write-back is handled elsewhere in the pipeline.
    assign owns_wb = (id_aluop == 4'b0001) || (id_aluop == 4'b1001) || (id_aluop == 4'b1010);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        funct_d   = funct_q;
        a_d       = a_q;
        b_d       = b_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = wr_en_q;
        sv_a_d    = sv_a_q;
        sv_op2_d  = sv_op2_q;

        if (flush) begin
            valid_d = 1'b0;
            wr_en_d = 1'b0;
            state_d = StPass;
        end else if (!hold) begin
            case (state_q)
                StPass: begin
                    if (id_valid) begin
                        valid_d   = 1'b1;
                        aluop_d   = id_aluop;
                        funct_d   = id_funct;
                        a_d       = id_a;
                        b_d       = id_b;
                        wr_addr_d = id_op1;
                        wr_en_d   = owns_wb;
                        if (is_swap) begin
                            funct_d  = FunctMove;
                            wr_en_d  = 1'b1;
                            sv_a_d   = id_a;
                            sv_op2_d = id_op2;
                            state_d  = StSwap2;
                        end
                    end else begin
                        valid_d = 1'b0;
                        wr_en_d = 1'b0;
                    end
                end
                StSwap2: begin
                    valid_d   = 1'b1;
                    aluop_d   = AluopAType;
                    funct_d   = FunctMove;
                    a_d       = '0;
                    b_d       = sv_a_q;
                    wr_addr_d = sv_op2_q;
                    wr_en_d   = 1'b1;
                    state_d   = StPass;
                end
                default: state_d = StPass;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StPass;
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            funct_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            sv_a_q    <= '0;
            sv_op2_q  <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            funct_q   <= funct_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            sv_a_q    <= sv_a_d;
            sv_op2_q  <= sv_op2_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_aluop   = aluop_q;
    assign ex_funct   = funct_q;
    assign ex_a       = a_q;
    assign ex_b       = b_q;
    assign ex_wr_addr = wr_addr_q;
    assign ex_wr_en   = wr_en_q;
    assign id_stall   = hold || (state_q == StSwap2);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomized bench for alu_issue_sequencer, checked against a micro-op queue model
// plus directed reset, pass-through, SWAP, flush and hold scenarios.
module tb_alu_issue_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst, id_valid, flush, hold;
    logic [3:0]    id_aluop, id_funct;
    logic [RW-1:0] id_op1, id_op2;
    logic [DW-1:0] id_a, id_b;
    logic          ex_valid, ex_wr_en, id_stall;
    logic [3:0]    ex_aluop, ex_funct;
    logic [DW-1:0] ex_a, ex_b;
    logic [RW-1:0] ex_wr_addr;

    always #5 clk = ~clk;

    alu_issue_sequencer #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_aluop  (id_aluop),
        .id_funct  (id_funct),
        .id_op1    (id_op1),
        .id_op2    (id_op2),
        .id_a      (id_a),
        .id_b      (id_b),
        .flush     (flush),
        .hold      (hold),
        .ex_valid  (ex_valid),
        .ex_aluop  (ex_aluop),
        .ex_funct  (ex_funct),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_wr_addr(ex_wr_addr),
        .ex_wr_en  (ex_wr_en),
        .id_stall  (id_stall)
    );

    typedef struct {
        logic          valid;
        logic [3:0]    aluop;
        logic [3:0]    funct;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] addr;
        logic          wren;
    } uop_t;

    uop_t   m;
    uop_t   pending[$];
    logic [31:0] mdl_w[$];
    logic [31:0] dut_w[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: one micro-op leaves per accepted edge; SWAP queues its second half.
    task automatic model_edge();
        uop_t u;
        if (rst) begin
            m = '{valid: 1'b0, aluop: '0, funct: '0, a: '0, b: '0, addr: '0, wren: 1'b0};
            pending.delete();
        end else if (flush) begin
            m.valid = 1'b0;
            m.wren  = 1'b0;
            pending.delete();
        end else if (!hold) begin
            if (pending.size() != 0) begin
                m = pending.pop_front();
                mdl_w.push_back({12'h0, m.addr, m.b});
            end else if (id_valid) begin
                m = '{valid: 1'b1, aluop: id_aluop, funct: id_funct, a: id_a, b: id_b,
                      addr: id_op1, wren: (id_aluop inside {4'd1, 4'd9, 4'd10})};
                if (id_aluop == 4'd1 && id_funct == 4'hf) begin
                    m.funct = 4'he;
                    m.wren  = 1'b1;
                    u = '{valid: 1'b1, aluop: 4'd1, funct: 4'he, a: '0, b: id_a,
                          addr: id_op2, wren: 1'b1};
                    pending.push_back(u);
                end
                if (m.wren) mdl_w.push_back({12'h0, m.addr, m.b});
            end else begin
                m.valid = 1'b0;
                m.wren  = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_aluop", 32'(ex_aluop), 32'(m.aluop));
        check("ex_funct", 32'(ex_funct), 32'(m.funct));
        check("ex_a", 32'(ex_a), 32'(m.a));
        check("ex_b", 32'(ex_b), 32'(m.b));
        check("ex_wr_addr", 32'(ex_wr_addr), 32'(m.addr));
        check("ex_wr_en", 32'(ex_wr_en), 32'(m.wren));
    endtask

    task automatic step(input logic r, input logic f, input logic h, input logic v,
                        input logic [3:0] op, input logic [3:0] fn,
                        input logic [RW-1:0] o1, input logic [RW-1:0] o2,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        rst = r; flush = f; hold = h; id_valid = v;
        id_aluop = op; id_funct = fn; id_op1 = o1; id_op2 = o2; id_a = a; id_b = b;
        #1;
        if (!r) check("id_stall", 32'(id_stall), 32'(h || pending.size() != 0));
        @(posedge clk);
        model_edge();
        #1;
        if (!r && !f && !h && ex_valid && ex_wr_en) dut_w.push_back({12'h0, ex_wr_addr, ex_b});
        compare_all();
    endtask

    task automatic rand_step(input logic r, input logic f, input logic h);
        logic [3:0] op, fn;
        op = 4'($urandom);
        fn = 4'($urandom);
        if ($urandom_range(2, 0) == 0) begin
            op = 4'd1;
            fn = 4'hf;
        end
        step(r, f, h, $urandom_range(3, 0) != 0, op, fn, 4'($urandom), 4'($urandom),
             16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
        id_aluop = '0; id_funct = '0; id_op1 = '0; id_op2 = '0; id_a = '0; id_b = '0;
        m = '{valid: 1'b0, aluop: '0, funct: '0, a: '0, b: '0, addr: '0, wren: 1'b0};

        // Reset with random inputs
        rand_step(1'b1, 1'b0, 1'b0);
        rand_step(1'b1, 1'b0, 1'b0);
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_b", 32'(ex_b), 32'd0);
        check("rst_wr_addr", 32'(ex_wr_addr), 32'd0);
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        #1 check("rst_stall", 32'(id_stall), 32'd0);

        // ADD pass-through, then store-class
        step(0, 0, 0, 1, 4'd1, 4'h0, 4'd3, 4'd4, 16'h0005, 16'h0007);
        check("add_wr_addr", 32'(ex_wr_addr), 32'd3);
        check("add_wr_en", 32'(ex_wr_en), 32'd1);
        check("add_b", 32'(ex_b), 32'h0007);
        check("add_stall", 32'(id_stall), 32'd0);
        step(0, 0, 0, 1, 4'd4, 4'h0, 4'd6, 4'd1, 16'h0001, 16'h0002);
        check("store_wr_en", 32'(ex_wr_en), 32'd0);

        // SWAP with a follower instruction held in ID
        step(0, 0, 0, 1, 4'd1, 4'hf, 4'd2, 4'd5, 16'h1111, 16'h2222);
        check("swap1_funct", 32'(ex_funct), 32'he);
        check("swap1_addr", 32'(ex_wr_addr), 32'd2);
        check("swap1_b", 32'(ex_b), 32'h2222);
        check("swap1_stall", 32'(id_stall), 32'd1);
        step(0, 0, 0, 1, 4'd9, 4'h3, 4'd7, 4'd8, 16'h00aa, 16'h00bb);
        check("swap2_addr", 32'(ex_wr_addr), 32'd5);
        check("swap2_b", 32'(ex_b), 32'h1111);
        step(0, 0, 0, 1, 4'd9, 4'h3, 4'd7, 4'd8, 16'h00aa, 16'h00bb);
        check("follow_addr", 32'(ex_wr_addr), 32'd7);

        // Flush in SWAP2
        step(0, 0, 0, 1, 4'd1, 4'hf, 4'd2, 4'd5, 16'h1111, 16'h2222);
        step(0, 1, 0, 1, 4'd0, 4'h0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_stall", 32'(id_stall), 32'd0);
        step(0, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'd0, 16'h0, 16'h0);

        // Hold in SWAP2 for 3 cycles
        step(0, 0, 0, 1, 4'd1, 4'hf, 4'd2, 4'd5, 16'h1111, 16'h2222);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 4'd3, 4'h2, 4'd9, 4'd9, 16'h0, 16'h0);
            check("hold_stall", 32'(id_stall), 32'd1);
            check("hold_addr", 32'(ex_wr_addr), 32'd2);
        end
        step(0, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("hold_rel_addr", 32'(ex_wr_addr), 32'd5);
        step(0, 0, 0, 0, 4'd0, 4'h0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("hold_rel_pass", 32'(ex_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rand_step($urandom_range(63, 0) == 0, $urandom_range(15, 0) == 0,
                      $urandom_range(3, 0) == 0);
        end

        check("wr_count", 32'(dut_w.size()), 32'(mdl_w.size()));
        for (int i = 0; i < dut_w.size() && i < mdl_w.size(); i++) begin
            check("wr_pair", dut_w[i], mdl_w[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_sequencer.md
# alu_issue_sequencer

Sits between the ID stage and the ID/EX register and feeds the ALU control unit one micro-op per cycle.
- Ordinary ALU instructions pass through with one cycle of latency.
- An A-type SWAP (ALUOP 0001, function 1111) is split into two MOVE micro-ops over two cycles, and IF/ID is stalled for the second cycle.
- A branch flush and a downstream hold are applied to the registered EX-side outputs.

## Interface
Parameters:
- DW, 16, operand data width
- RW, 4, register address width

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous reset, active high
- id_valid  in  1  ID stage holds a valid instruction
- id_aluop  in  4  ALUOP field from decode
- id_funct  in  4  function code from decode
- id_op1  in  RW  op1 register address (destination of A-type)
- id_op2  in  RW  op2 register address
- id_a  in  DW  value read from op1
- id_b  in  DW  value read from op2
- flush  in  1  kill the micro-op in EX and abort any split (branch taken)
- hold  in  1  downstream stall; freeze all state
- ex_valid  out  1  micro-op valid
- ex_aluop  out  4  ALUOP to the ALU control unit
- ex_funct  out  4  function code to the ALU control unit
- ex_a  out  DW  ALU operand A
- ex_b  out  DW  ALU operand B
- ex_wr_addr  out  RW  write-back register
- ex_wr_en  out  1  register write-back enable
- id_stall  out  1  hold IF/ID (combinational)

## Operation
The sequencer has two states, PASS and SWAP2, plus save registers sv_a (DW) and sv_op2 (RW). Updates below apply only on edges where rst, flush and hold are all 0.

PASS, id_valid=1, not SWAP:
- ex_valid=1.
- ex_aluop, ex_funct, ex_a and ex_b are copied from the id_* inputs.
- ex_wr_addr=id_op1.
- ex_wr_en=1 iff id_aluop is 0001, 1001 or 1010; otherwise 0 (load, store and branch write-back is not owned here).

PASS, id_valid=0:
- ex_valid=0 and ex_wr_en=0.
- The other ex_* outputs keep their previous values.

PASS, SWAP (id_valid=1, id_aluop=0001, id_funct=1111), first half:
- Issue ex_aluop=0001, ex_funct=1110 (MOVE, result = B).
- ex_a=id_a, ex_b=id_b, ex_wr_addr=id_op1, ex_wr_en=1, ex_valid=1.
- Capture sv_a<=id_a and sv_op2<=id_op2.
- Next state is SWAP2.

SWAP2, second half:
- Issue ex_aluop=0001, ex_funct=1110.
- ex_a=0, ex_b=sv_a, ex_wr_addr=sv_op2, ex_wr_en=1, ex_valid=1.
- The ID inputs are ignored.
- Next state is PASS.

Other rules:
- id_stall = hold OR (state==SWAP2).
- id_op1==id_op2 on SWAP: both halves write the same register with its own value. No special case.
- The SWAP encoding is fixed. Any other A-type function code passes through unchanged.

Priority on each edge: rst > flush > hold > normal operation.
- rst: state=PASS, all ex_* outputs = 0, sv_a=0, sv_op2=0.
- flush: ex_valid=0, ex_wr_en=0, state=PASS. A flush in SWAP2 drops the second half. Other registers hold.
- hold: every register, including state and the save registers, keeps its value.

## Timing
- Latency from an ID input to the ex_* outputs is 1 cycle; all ex_* outputs are registered.
- Throughput is one instruction per cycle, except SWAP, which takes two cycles.
- id_stall:
  - Asserts in the same cycle the state register reads SWAP2, i.e. the cycle after the SWAP is accepted.
  - The instruction that reached ID during that cycle is held, then accepted in the next PASS cycle.
- Reset values: state PASS, ex_valid 0, ex_wr_en 0, ex_aluop/ex_funct/ex_a/ex_b/ex_wr_addr 0, sv_a and sv_op2 0. id_stall equals hold.
- Reset while in SWAP2: the next state is PASS and the second half is lost. This is acceptable.
- Hold while in SWAP2:
  - State stays SWAP2 and the outputs stay frozen.
  - The second half issues on the first edge after hold falls.
- Flush and hold asserted together: flush wins.

## Test plan
- Reset: hold rst high for 2 cycles with random inputs → every ex_* output is 0 and id_stall=0 (hold=0).
- ADD pass-through: aluop=0001, funct=0000, op1=3, a=0x0005, b=0x0007 → next cycle ex_valid=1, ex_funct=0000, ex_wr_addr=3, ex_wr_en=1, ex_a=0x0005, ex_b=0x0007, id_stall=0. A store-class aluop (e.g. 0100) gives ex_wr_en=0.
- SWAP:
  - Stimulus: op1=2, op2=5, a=0x1111, b=0x2222.
  - Cycle+1: funct=1110, wr_addr=2, ex_b=0x2222, id_stall=1.
  - Cycle+2: funct=1110, wr_addr=5, ex_b=0x1111.
  - The instruction after the SWAP issues at cycle+3.
- Flush in SWAP2: as the SWAP test, but assert flush in the SWAP2 cycle → next cycle ex_valid=0, ex_wr_en=0, state PASS, id_stall=0. No write to register 5 is issued.
- Hold in SWAP2: hold=1 for 3 cycles → outputs frozen and id_stall=1 throughout. After release, the second half issues once, then state returns to PASS.
- Back-to-back SWAPs with id_valid gaps and random hold → compare against a reference model. The stream of (wr_addr, ex_b) write pairs matches exactly with no duplicates or drops.
